// File: rtl/wdg_pkg.sv
// Shared types and defaults for the watchdog reset generator.
package wdg_pkg;

    typedef enum logic [1:0] {IDLE, ASSERT, GUARD} wdg_rst_state_e;

    localparam int unsigned DEF_MIN_LEN   = 2;
    localparam int unsigned DEF_GUARD_CYC = 8;
    localparam int unsigned RST_CNT_WIDTH = 8;

endpackage

// File: rtl/wdg_rst_timer.sv
// Loadable down-counter with zero flag; shared by the ASSERT and GUARD phases.
module wdg_rst_timer #(
    parameter int unsigned LEN_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 load_i,
    input  logic [LEN_WIDTH-1:0] load_val_i,
    input  logic                 dec_i,
    output logic [LEN_WIDTH-1:0] cnt_o,
    output logic                 zero_o
);

    logic [LEN_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - LEN_WIDTH'(1);
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/wdg_rst_gen.sv
// Watchdog reset pulse generator: trigger -> programmable reset pulse -> guard window.
// Optional saturating reset counter built when WDG_RST_CNT_EN is defined.
module wdg_rst_gen
    import wdg_pkg::*;
#(
    parameter int unsigned LEN_WIDTH = 16,
    parameter int unsigned GUARD_CYC = DEF_GUARD_CYC,
    parameter int unsigned MIN_LEN   = DEF_MIN_LEN
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     en_i,
    input  logic                     trig_i,
    input  logic [LEN_WIDTH-1:0]     rst_len_i,
    input  logic                     clr_cause_i,
    output logic                     rst_o,
    output logic                     busy_o,
    output logic                     cause_o,
    output logic [RST_CNT_WIDTH-1:0] rst_cnt_o
);

    wdg_rst_state_e state_q, state_d;
    logic rst_q, rst_d;
    logic busy_q, busy_d;
    logic cause_q, cause_d;
    logic accept;

    logic                 tmr_load;
    logic                 tmr_dec;
    logic [LEN_WIDTH-1:0] tmr_val;
    logic [LEN_WIDTH-1:0] tmr_cnt;
    logic                 tmr_zero;

    logic [LEN_WIDTH-1:0] min_len;
    logic [LEN_WIDTH-1:0] eff_len;

    assign min_len = LEN_WIDTH'(MIN_LEN);
    assign eff_len = (rst_len_i < min_len) ? min_len : rst_len_i;

    wdg_rst_timer #(
        .LEN_WIDTH (LEN_WIDTH)
    ) u_timer (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .dec_i      (tmr_dec),
        .cnt_o      (tmr_cnt),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        rst_d    = rst_q;
        busy_d   = busy_q;
        cause_d  = cause_q;
        accept   = 1'b0;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        tmr_val  = '0;

        unique case (state_q)
            IDLE: begin
                if (trig_i && en_i) begin
                    accept   = 1'b1;
                    state_d  = ASSERT;
                    rst_d    = 1'b1;
                    busy_d   = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = eff_len - LEN_WIDTH'(1);
                end
            end
            // Triggers and en_i are deliberately not looked at while busy.
            ASSERT: begin
                if (tmr_zero) begin
                    state_d  = GUARD;
                    rst_d    = 1'b0;
                    tmr_load = 1'b1;
                    tmr_val  = LEN_WIDTH'(GUARD_CYC - 1);
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            GUARD: begin
                if (tmr_zero) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                rst_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        // A new acceptance wins over a simultaneous clear.
        if (accept) begin
            cause_d = 1'b1;
        end else if (clr_cause_i) begin
            cause_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            rst_q   <= 1'b0;
            busy_q  <= 1'b0;
            cause_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rst_q   <= rst_d;
            busy_q  <= busy_d;
            cause_q <= cause_d;
        end
    end

`ifdef WDG_RST_CNT_EN
    logic [RST_CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            if (clr_cause_i) begin
                cnt_d = RST_CNT_WIDTH'(1);
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + RST_CNT_WIDTH'(1);
            end
        end else if (clr_cause_i) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign rst_cnt_o = cnt_q;
`else
    assign rst_cnt_o = '0;
`endif

    assign rst_o   = rst_q;
    assign busy_o  = busy_q;
    assign cause_o = cause_q;

endmodule

// File: tb/tb_wdg_rst_gen.sv
// Self-checking bench for wdg_rst_gen against a cycle-window reference model.
module tb_wdg_rst_gen;

    localparam int unsigned LW    = 16;
    localparam int          GUARD = 8;
    localparam int          MINL  = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          trig;
    logic [LW-1:0] rst_len;
    logic          clr_cause;
    logic          rst_out;
    logic          busy;
    logic          cause;
    logic [7:0]    rst_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: absolute edge indices bounding the current/last pulse and busy window.
    int k         = 0;
    int rst_last  = -1;
    int busy_last = -1;
    bit m_cause   = 1'b0;
    int m_cnt     = 0;

    always #5 clk = ~clk;

    wdg_rst_gen #(
        .LEN_WIDTH (LW),
        .GUARD_CYC (GUARD),
        .MIN_LEN   (MINL)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .en_i        (en),
        .trig_i      (trig),
        .rst_len_i   (rst_len),
        .clr_cause_i (clr_cause),
        .rst_o       (rst_out),
        .busy_o      (busy),
        .cause_o     (cause),
        .rst_cnt_o   (rst_cnt)
    );

    task automatic check(input string tag);
        logic       e_rst;
        logic       e_busy;
        logic       e_cause;
        logic [7:0] e_cnt;
        e_rst   = (k <= rst_last);
        e_busy  = (k <= busy_last);
        e_cause = m_cause;
`ifdef WDG_RST_CNT_EN
        e_cnt   = 8'(m_cnt);
`else
        e_cnt   = 8'h00;
`endif
        n_assert++;
        assert (rst_out === e_rst) else begin
            n_fail++;
            $error("FAIL %s rst_o k=%0d got %b exp %b", tag, k, rst_out, e_rst);
        end
        n_assert++;
        assert (busy === e_busy) else begin
            n_fail++;
            $error("FAIL %s busy_o k=%0d got %b exp %b", tag, k, busy, e_busy);
        end
        n_assert++;
        assert (cause === e_cause) else begin
            n_fail++;
            $error("FAIL %s cause_o k=%0d got %b exp %b", tag, k, cause, e_cause);
        end
        n_assert++;
        assert (rst_cnt === e_cnt) else begin
            n_fail++;
            $error("FAIL %s rst_cnt_o k=%0d got %0d exp %0d", tag, k, rst_cnt, e_cnt);
        end
    endtask

    // One clock: drive inputs, advance the model by one edge, check outputs after the edge.
    task automatic step(input logic t, input logic e, input logic [LW-1:0] l,
                        input logic c, input logic r, input string tag);
        int len;
        trig      = t;
        en        = e;
        rst_len   = l;
        clr_cause = c;
        rst_n     = r;
        @(posedge clk);
        k++;
        if (!r) begin
            rst_last  = -1;
            busy_last = -1;
            m_cause   = 1'b0;
            m_cnt     = 0;
        end else if (t && e && (k - 1 > busy_last)) begin
            len       = (int'(l) < MINL) ? MINL : int'(l);
            rst_last  = k + len - 1;
            busy_last = k + len + GUARD - 1;
            m_cause   = 1'b1;
            m_cnt     = c ? 1 : ((m_cnt == 255) ? 255 : m_cnt + 1);
        end else if (c) begin
            m_cause = 1'b0;
            m_cnt   = 0;
        end
        #1;
        check(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, LW'(5), 1'b0, 1'b1, tag);
    endtask

    initial begin
        trig = 1'b0; en = 1'b0; rst_len = '0; clr_cause = 1'b0; rst_n = 1'b0;

        step(1'b0, 1'b0, '0, 1'b0, 1'b0, "reset");
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, "reset");
        idle(2, "idle");

        // Basic pulse with triggers inside ASSERT and on the last GUARD cycle.
        step(1'b1, 1'b1, LW'(5), 1'b0, 1'b1, "len5");
        for (int i = 1; i <= 14; i++)
            step((i == 3) || (i == 5 + GUARD - 1), 1'b1, LW'(5), 1'b0, 1'b1, "len5_ign");
        step(1'b1, 1'b1, LW'(3), 1'b0, 1'b1, "retrig");
        idle(14, "retrig");

        step(1'b1, 1'b1, LW'(0), 1'b0, 1'b1, "len0");
        idle(12, "len0");
        step(1'b1, 1'b1, LW'(1), 1'b0, 1'b1, "len1");
        step(1'b0, 1'b1, LW'(40), 1'b0, 1'b1, "len1_chg");
        idle(11, "len1");

        step(1'b1, 1'b0, LW'(4), 1'b0, 1'b1, "en0");
        idle(3, "en0");
        step(1'b0, 1'b1, LW'(4), 1'b1, 1'b1, "clr");
        step(1'b1, 1'b1, LW'(4), 1'b1, 1'b1, "clr_set");
        step(1'b0, 1'b0, LW'(4), 1'b1, 1'b1, "clr_in_assert");
        idle(14, "clr_set");

        // Reset aborts an in-flight pulse; the next one is full length.
        step(1'b1, 1'b1, LW'(10), 1'b0, 1'b1, "abort");
        idle(3, "abort");
        step(1'b0, 1'b1, LW'(10), 1'b0, 1'b0, "abort_rst");
        step(1'b1, 1'b1, LW'(6), 1'b0, 1'b1, "after_rst");
        idle(16, "after_rst");

        step(1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b1, "max_len");
        idle(65535 + GUARD + 2, "max_len");

        for (int n = 0; n < 300; n++) begin
            step(1'b1, 1'b1, LW'(0), 1'b0, 1'b1, "sat");
            idle(MINL + GUARD, "sat");
        end
        step(1'b0, 1'b1, LW'(0), 1'b1, 1'b1, "sat_clr");

        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(3) == 0), ($urandom_range(7) != 0), LW'($urandom_range(7)),
                 ($urandom_range(15) == 0), ($urandom_range(99) != 0), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
